// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED bank: atomic set/clear/toggle and byte-lane writes,
// per-LED hardware blink from a programmable prescaler, registered readback.
module led_bank_ctrl #(
    parameter int unsigned      NUM_LEDS      = 24,
    parameter int unsigned      DATA_W        = 32,
    parameter int unsigned      DIV_W         = 24,
    parameter logic [DIV_W-1:0] BLINK_DIV_RST = 24'd4_999_999
) (
    input  logic                led_clk,
    input  logic                ledrst,
    input  logic                ledcs,
    input  logic                ledwrite,
    input  logic [3:0]          ledaddr,
    input  logic [DATA_W-1:0]   ledwdata,
    output logic [DATA_W-1:0]   ledrdata,
    output logic [NUM_LEDS-1:0] ledout
);

    typedef enum logic [3:0] {
        REG_DATA   = 4'h0,
        REG_SET    = 4'h1,
        REG_CLR    = 4'h2,
        REG_TOG    = 4'h3,
        REG_LANE   = 4'h4,
        REG_BMASK  = 4'h5,
        REG_BDIV   = 4'h6,
        REG_STATUS = 4'h7
    } reg_e;

    logic [NUM_LEDS-1:0] state, state_n;
    logic [NUM_LEDS-1:0] mask, mask_n;
    logic [DIV_W-1:0]    div, div_n;
    logic [DIV_W-1:0]    counter, counter_n;
    logic                phase, phase_n;
    logic [DATA_W-1:0]   rdata_n;
    logic [NUM_LEDS-1:0] ledout_n;
    logic [NUM_LEDS-1:0] wbits;
    logic [NUM_LEDS-1:0] lane_hit;
    logic [NUM_LEDS-1:0] lane_bits;

    assign wbits = ledwdata[NUM_LEDS-1:0];

    // Lanes past the top LED select no bits, so out-of-range lanes fall out naturally.
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_lane
        assign lane_hit[g]  = (ledwdata[15:8] == 8'(g / 8));
        assign lane_bits[g] = ledwdata[g % 8];
    end

    always_comb begin
        state_n = state;
        mask_n  = mask;
        div_n   = div;
        rdata_n = ledrdata;

        if (counter == div) begin
            counter_n = '0;
            phase_n   = ~phase;
        end else begin
            counter_n = counter + DIV_W'(1);
            phase_n   = phase;
        end

        if (ledcs && ledwrite) begin
            case (ledaddr)
                REG_DATA:  state_n = wbits;
                REG_SET:   state_n = state | wbits;
                REG_CLR:   state_n = state & ~wbits;
                REG_TOG:   state_n = state ^ wbits;
                REG_LANE:  state_n = (state & ~lane_hit) | (lane_bits & lane_hit);
                REG_BMASK: mask_n  = wbits;
                REG_BDIV: begin
                    div_n     = ledwdata[DIV_W-1:0];
                    counter_n = '0;
                    phase_n   = 1'b0;
                end
                default: ;
            endcase
        end

        if (ledcs && !ledwrite) begin
            rdata_n = '0;
            case (ledaddr)
                REG_DATA, REG_SET, REG_CLR, REG_TOG: rdata_n[NUM_LEDS-1:0] = state;
                REG_BMASK: rdata_n[NUM_LEDS-1:0] = mask;
                REG_BDIV:  rdata_n[DIV_W-1:0]    = div;
                REG_STATUS: begin
                    rdata_n[DIV_W:1] = counter;
                    rdata_n[0]       = phase;
                end
                default: ;
            endcase
        end

        // Display uses next-state values so a write is visible at its own edge.
        ledout_n = state_n & ~(mask_n & {NUM_LEDS{phase_n}});
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            state    <= '0;
            mask     <= '0;
            div      <= BLINK_DIV_RST;
            counter  <= '0;
            phase    <= 1'b0;
            ledout   <= '0;
            ledrdata <= '0;
        end else begin
            state    <= state_n;
            mask     <= mask_n;
            div      <= div_n;
            counter  <= counter_n;
            phase    <= phase_n;
            ledout   <= ledout_n;
            ledrdata <= rdata_n;
        end
    end

endmodule

// File: doc/led_bank_ctrl.md
# led_bank_ctrl

Parametrised memory-mapped LED output controller on the CPU I/O bus, selected by the MemOrIO chip-select alongside the switch and segment peripherals. It holds a NUM_LEDS-wide LED state register with atomic set/clear/toggle writes and byte-lane writes. It also provides a per-LED hardware blink function driven by a programmable prescaler, plus registered readback of every control register.

## Interface
Parameters:
- NUM_LEDS, 24: number of board LEDs driven; legal range 1..DATA_W.
- DATA_W, 32: bus data width.
- DIV_W, 24: width of the blink divider and counter.
- BLINK_DIV_RST, 24'd4_999_999: reset value of the blink half-period register.

Ports:
- led_clk  in  1  CPU clock; all state changes on its rising edge.
- ledrst  in  1  asynchronous active-high reset.
- ledcs  in  1  chip select from MemOrIO; 1 = this block addressed.
- ledwrite  in  1  1 = write cycle, 0 = read cycle; ignored when ledcs=0.
- ledaddr  in  4  register select.
- ledwdata  in  DATA_W  write data.
- ledrdata  out  DATA_W  registered read data, zero-extended.
- ledout  out  NUM_LEDS  registered LED drive, 1 = LED on.

## Operation
Register map (write effect / read value):
- 0x0 DATA: state <= wdata[NUM_LEDS-1:0] / state.
- 0x1 SET: state <= state | wdata / state.
- 0x2 CLR: state <= state & ~wdata / state.
- 0x3 TOG: state <= state ^ wdata / state.
- 0x4 LANE: lane = wdata[15:8], byte = wdata[7:0]; state bits [8*lane+7 : 8*lane] <= byte, truncated at NUM_LEDS-1. A lane >= ceil(NUM_LEDS/8) is ignored / read returns 0.
- 0x5 BMASK: mask <= wdata[NUM_LEDS-1:0] / mask.
- 0x6 BDIV: div <= wdata[DIV_W-1:0]; counter <= 0; phase <= 0 / div.
- 0x7 STATUS: read-only; bit0 = phase, bits[DIV_W:1] = counter. Writes ignored.
- 0x8-0xF: writes ignored, reads 0.

Blink engine:
- Counter runs continuously from 0 to div. At counter==div, counter <= 0 and phase toggles; otherwise counter increments.
- div=0: phase toggles every cycle.
- Display function: ledout <= next_state & ~(next_mask & {NUM_LEDS{next_phase}}). Blinking LEDs are forced off while phase=1. Non-blinking LEDs follow state.

Bit handling:
- wdata bits at or above NUM_LEDS are ignored.
- Readback zero-extends to DATA_W.

## Timing
- Reset (ledrst=1, asynchronous): state=0, mask=0, div=BLINK_DIV_RST, counter=0, phase=0, ledout=0, ledrdata=0. These values hold while ledrst is high.
- Reset deasserted mid-blink or mid-access: all work is lost and the block restarts from reset values. The first counted edge is the first rising edge with ledrst low.
- Writes: a write is sampled at rising edge k when ledcs=1 and ledwrite=1. The register is updated at edge k. ledout reflects the write at edge k, because it is computed from next-state values. Zero-cycle visible latency, glitch-free.
- Reads: ledcs=1 and ledwrite=0 at edge k loads ledrdata at edge k, valid through the next cycle. When no read is sampled, ledrdata holds its value. A read returns the register value from before any same-edge update (only reads occur on read cycles, so this does not collide).
- One access per cycle; back-to-back writes are each applied in order, one per edge.
- Write to BDIV at the same edge the counter reaches div: the write wins (counter=0, phase=0, no toggle).
- Write to BMASK or state at the same edge as a phase toggle: ledout uses the new mask/state and the new phase.
- ledcs=0: no register changes except the blink counter and phase.

## Test plan
- Reset: assert ledrst asynchronously mid-cycle with state=0xFFFFFF -> ledout=0 and ledrdata=0 immediately, without waiting for a clock edge. Read BDIV after release -> 4_999_999.
- Atomic ops (NUM_LEDS=24): DATA=0x00F0F0, SET 0x0F0000, CLR 0x000F00, TOG 0x0000FF -> ledout 0x0FF0F0, then 0x0FF0F0, then 0x0FF00F. Each value visible at its write edge.
- Lane writes: LANE wdata=0x0000_02A5 -> state[23:16]=0xA5. Lane 3 write -> no change, read returns 0. NUM_LEDS=20 build, lane 2 byte 0xFF -> state[19:16]=0xF.
- Blink: BDIV=3, BMASK=0x000001, DATA=0x000003 -> ledout alternates 0x3 / 0x2 every 4 cycles. Writing BDIV at the terminal count restarts with phase 0.
- div=0 and collision: BDIV=0 -> masked LED toggles every cycle. BMASK write coincident with a toggle -> the new mask applies on that edge.
- Readback/ignore: read each of 0x0-0x7 -> registered values one edge later. Write to 0x7/0x9 -> no state change. Read 0xC -> 0. A write with ledcs=0 -> ignored.
